// File: rtl/idct_sched_pkg.sv
// Shared types and constants for the IDCT reverse-order frame scheduler.
package idct_sched_pkg;

  localparam int MAX_PTS = 2048;
  localparam int wAddr   = 11;

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_RUN}  rstate_t;

  typedef struct packed {
    logic        full;
    logic [11:0] npts;
    logic [1:0]  err;
  } bank_stat_t;

  // Frame length must be a power of two in [2, MAX_PTS].
  function automatic logic pts_ok(input logic [11:0] n);
    return (n >= 12'd2) && (n <= 12'(MAX_PTS)) && ((n & (n - 12'd1)) == 12'd0);
  endfunction

endpackage

// File: rtl/idct_pp_ram.sv
// One frame bank: single write port, two registered read ports sharing one read enable.
module idct_pp_ram
  import idct_sched_pkg::*;
#(
  parameter int wWord = 48,
  parameter int DEPTH = MAX_PTS
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [wAddr-1:0] waddr_i,
  input  logic [wWord-1:0] wdata_i,
  input  logic             re_i,
  input  logic [wAddr-1:0] raddr_a_i,
  input  logic [wAddr-1:0] raddr_b_i,
  output logic [wWord-1:0] rdata_a_o,
  output logic [wWord-1:0] rdata_b_o
);

  logic [wWord-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) begin
      rdata_a_o <= mem_q[raddr_a_i];
      rdata_b_o <= mem_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/idct_rev_sched.sv
// Ping-pong scheduler replaying each frame as pairs D(k), D((N-k) mod N).
// The bank RAM read registers form the data half of the output register.
//
// state  | meaning
// W_IDLE | waiting for an accepted sop beat
// W_FILL | writing beats 1..N-1 of the current frame
// R_IDLE | waiting for the read-pointer bank to fill
// R_RUN  | issuing addresses k=1..N-1 of the current bank
module idct_rev_sched
  import idct_sched_pkg::*;
#(
  parameter int wData = 24
) (
  input  logic             clk,
  input  logic             rst_sync,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic [1:0]       sink_error,
  input  logic             sink_sop,
  input  logic             sink_eop,
  input  logic [wData-1:0] sink_real,
  input  logic [wData-1:0] sink_imag,
  input  logic [11:0]      fftpts_in,
  output logic             source_valid,
  input  logic             source_ready,
  output logic [1:0]       source_error,
  output logic             source_sop,
  output logic             source_eop,
  output logic [wData-1:0] source_real,
  output logic [wData-1:0] source_imag,
  output logic [wData-1:0] source_real_rev,
  output logic [wData-1:0] source_imag_rev,
  output logic [11:0]      fftpts_out,
  output logic             frame_err
);

  localparam int wWord = 2 * wData;

  wstate_t          wstate_q, wstate_d;
  rstate_t          rstate_q, rstate_d;
  bank_stat_t [1:0] bank_q, bank_d;
  logic             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [wAddr-1:0] cnt_q, cnt_d, k_q, k_d;
  logic [11:0]      wn_q, wn_d;
  logic [1:0]       werr_q, werr_d;
  logic             frame_err_q, frame_err_d;

  logic             ovalid_q, osop_q, oeop_q, obank_q;
  logic [1:0]       oerr_q;
  logic [11:0]      onpts_q;

  logic             accept, we, commit, en, issue, last, free;
  logic [wAddr-1:0] waddr, cur_k, rev_k, nlo;
  logic [11:0]      rd_n;
  logic [wWord-1:0] rdat_a [2];
  logic [wWord-1:0] rdat_b [2];
  logic [wWord-1:0] sel_a, sel_b;

  assign sink_ready = !bank_q[wptr_q].full;
  assign accept     = sink_valid && sink_ready;

  always_comb begin
    wstate_d    = wstate_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    wn_d        = wn_q;
    werr_d      = werr_q;
    frame_err_d = frame_err_q;
    we          = 1'b0;
    waddr       = cnt_q;
    commit      = 1'b0;
    if (accept) begin
      if (sink_sop) begin
        // A sop always (re)starts the frame; inside W_FILL it also discards the partial one.
        if (wstate_q == W_FILL) frame_err_d = 1'b1;
        if (!pts_ok(fftpts_in) || sink_eop) begin
          frame_err_d = 1'b1;
          wstate_d    = W_IDLE;
        end else begin
          we       = 1'b1;
          waddr    = '0;
          wn_d     = fftpts_in;
          werr_d   = sink_error;
          cnt_d    = wAddr'(1);
          wstate_d = W_FILL;
        end
      end else if (wstate_q == W_IDLE) begin
        frame_err_d = 1'b1;
      end else begin
        we     = 1'b1;
        werr_d = werr_q | sink_error;
        if (cnt_q == wn_q[wAddr-1:0] - wAddr'(1)) begin
          wstate_d = W_IDLE;
          if (sink_eop) begin
            commit = 1'b1;
            wptr_d = ~wptr_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sink_eop) begin
          frame_err_d = 1'b1;
          wstate_d    = W_IDLE;
        end else begin
          cnt_d = cnt_q + wAddr'(1);
        end
      end
    end
  end

  assign en    = !ovalid_q || source_ready;
  assign rd_n  = bank_q[rptr_q].npts;
  assign nlo   = rd_n[wAddr-1:0];
  assign cur_k = (rstate_q == R_RUN) ? k_q : '0;
  // Low-bit arithmetic also covers N=MAX_PTS, where nlo wraps to zero.
  assign rev_k = (nlo - cur_k) & (nlo - wAddr'(1));
  assign last  = (cur_k == nlo - wAddr'(1));
  assign issue = en && ((rstate_q == R_RUN) || bank_q[rptr_q].full);

  always_comb begin
    rstate_d = rstate_q;
    rptr_d   = rptr_q;
    k_d      = k_q;
    free     = 1'b0;
    if (issue) begin
      if (last) begin
        // R_IDLE picks up an already-full next bank in the following cycle, so no bubble.
        free     = 1'b1;
        rptr_d   = ~rptr_q;
        rstate_d = R_IDLE;
        k_d      = '0;
      end else begin
        rstate_d = R_RUN;
        k_d      = cur_k + wAddr'(1);
      end
    end
  end

  always_comb begin
    bank_d = bank_q;
    if (free)   bank_d[rptr_q].full = 1'b0;
    if (commit) bank_d[wptr_q] = bank_stat_t'{full: 1'b1, npts: wn_q, err: werr_q | sink_error};
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      wstate_q    <= W_IDLE;
      rstate_q    <= R_IDLE;
      bank_q      <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= '0;
      k_q         <= '0;
      wn_q        <= '0;
      werr_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      rstate_q    <= rstate_d;
      bank_q      <= bank_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      wn_q        <= wn_d;
      werr_q      <= werr_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      ovalid_q <= 1'b0;
      osop_q   <= 1'b0;
      oeop_q   <= 1'b0;
      obank_q  <= 1'b0;
      oerr_q   <= '0;
      onpts_q  <= '0;
    end else if (en) begin
      ovalid_q <= issue;
      osop_q   <= issue && (cur_k == '0);
      oeop_q   <= issue && last;
      if (issue) begin
        obank_q <= rptr_q;
        oerr_q  <= bank_q[rptr_q].err;
        onpts_q <= rd_n;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    idct_pp_ram #(.wWord(wWord), .DEPTH(MAX_PTS)) u_ram (
      .clk       (clk),
      .we_i      (we && (wptr_q == 1'(b))),
      .waddr_i   (waddr),
      .wdata_i   ({sink_real, sink_imag}),
      .re_i      (issue && (rptr_q == 1'(b))),
      .raddr_a_i (cur_k),
      .raddr_b_i (rev_k),
      .rdata_a_o (rdat_a[b]),
      .rdata_b_o (rdat_b[b])
    );
  end

  assign sel_a = obank_q ? rdat_a[1] : rdat_a[0];
  assign sel_b = obank_q ? rdat_b[1] : rdat_b[0];

  assign source_valid    = ovalid_q;
  assign source_sop      = osop_q;
  assign source_eop      = oeop_q;
  assign source_error    = oerr_q;
  assign fftpts_out      = onpts_q;
  assign frame_err       = frame_err_q;
  assign source_real     = ovalid_q ? sel_a[wWord-1:wData] : '0;
  assign source_imag     = ovalid_q ? sel_a[wData-1:0]     : '0;
  assign source_real_rev = ovalid_q ? sel_b[wWord-1:wData] : '0;
  assign source_imag_rev = ovalid_q ? sel_b[wData-1:0]     : '0;

endmodule

// File: tb/tb_idct_rev_sched.sv
// Scoreboard bench for idct_rev_sched: driver queues expected beats, monitor pops on handshake.
module tb_idct_rev_sched;

  localparam int wData = 24;
  typedef logic [111:0] beat_t;

  logic             clk, rst_sync;
  logic             sink_valid, sink_ready, sink_sop, sink_eop;
  logic [1:0]       sink_error;
  logic [wData-1:0] sink_real, sink_imag;
  logic [11:0]      fftpts_in;
  logic             source_valid, source_ready, source_sop, source_eop, frame_err;
  logic [1:0]       source_error;
  logic [wData-1:0] source_real, source_imag, source_real_rev, source_imag_rev;
  logic [11:0]      fftpts_out;

  idct_rev_sched #(.wData(wData)) dut (
    .clk(clk), .rst_sync(rst_sync),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .fftpts_in(fftpts_in),
    .source_valid(source_valid), .source_ready(source_ready), .source_error(source_error),
    .source_sop(source_sop), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag),
    .source_real_rev(source_real_rev), .source_imag_rev(source_imag_rev),
    .fftpts_out(fftpts_out), .frame_err(frame_err)
  );

  int    total = 0, bad = 0;
  int    cyc = 0, eop_cyc = 0, sop_cyc = 0, prev_cyc = 0;
  bit    chk_contig = 0, have_prev = 0, rdy_toggle = 0, hold_pend = 0;
  beat_t held;
  beat_t exp_q [$];
  beat_t cur;

  assign cur = {source_sop, source_eop, source_error, fftpts_out,
                source_real, source_imag, source_real_rev, source_imag_rev};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  function automatic beat_t mk(input int n, input int k, input int br, input int bi,
                               input logic [1:0] e);
    int r;
    r = (n - k) % n;
    return {(k == 0), (k == n - 1), e, 12'(n),
            24'(br + k), 24'(bi + k), 24'(br + r), 24'(bi + r)};
  endfunction

  // nb beats, eop on beat eop_at (-1: none), error ev on beat eb (-1: none)
  task automatic send_frame(input int n, input int nb, input int eop_at, input int br,
                            input int bi, input int eb, input logic [1:0] ev, input bit want);
    if (want)
      for (int k = 0; k < n; k++) exp_q.push_back(mk(n, k, br, bi, (eb >= 0) ? ev : 2'b00));
    for (int j = 0; j < nb; j++) begin
      int w;
      sink_valid = 1'b1;
      sink_sop   = (j == 0);
      sink_eop   = (j == eop_at);
      sink_real  = 24'(br + j);
      sink_imag  = 24'(bi + j);
      sink_error = (j == eb) ? ev : 2'b00;
      fftpts_in  = 12'(n);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!sink_ready && w < 400);
      if (!sink_ready) begin
        total++;
        bad++;
        $display("FAIL sink_timeout got=ready0 want=ready1 beat=%0d", j);
        sink_valid = 1'b0;
        return;
      end
      if (sink_eop) eop_cyc = cyc;
      @(posedge clk);
      #1;
    end
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    sink_error = 2'b00;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 600) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_sync) begin
      hold_pend = 0;
    end else begin
      if (hold_pend) chk("hold", {source_valid, cur}, {1'b1, held});
      hold_pend = 0;
      if (source_valid) begin
        if (source_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat got=%h want=none", cur);
          end else begin
            chk("beat", cur, exp_q.pop_front());
          end
          if (source_sop) sop_cyc = cyc;
          if (chk_contig) begin
            if (have_prev) chk("contig", cyc, prev_cyc + 1);
            have_prev = 1;
            prev_cyc  = cyc;
          end
        end else begin
          held      = cur;
          hold_pend = 1;
        end
      end
    end
  end

  initial begin
    logic [3:0] pat;
    int t;
    pat = 4'b1001;
    t = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) begin
        source_ready = pat[3 - (t % 4)];
        t++;
      end
    end
  end

  initial begin
    rst_sync = 1; sink_valid = 0; sink_sop = 0; sink_eop = 0; sink_error = 0;
    sink_real = 0; sink_imag = 0; fftpts_in = 0; source_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_sync = 0;
    @(negedge clk);
    chk("rst_valid", source_valid, 0);
    chk("rst_ready", sink_ready, 1);
    chk("rst_ferr", frame_err, 0);
    chk("rst_outs", {source_sop, source_eop, source_error, fftpts_out, source_real}, 0);
    @(posedge clk); #1;

    // basic N=8, latency eop->sop of 2
    send_frame(8, 8, 7, 0, 100, -1, 2'b00, 1);
    drain();
    chk("latency", sop_cyc - eop_cyc, 2);

    // back-to-back N=16 then N=8
    have_prev = 0; chk_contig = 1;
    send_frame(16, 16, 15, 200, 300, -1, 2'b00, 1);
    send_frame(8, 8, 7, 400, 500, -1, 2'b00, 1);
    drain();
    chk_contig = 0;
    chk("contig_len", prev_cyc - sop_cyc, 7);

    // output stalls with ready pattern 1,0,0,1
    rdy_toggle = 1;
    send_frame(8, 8, 7, 0, 100, -1, 2'b00, 1);
    drain();
    rdy_toggle = 0;

    // both banks fill while downstream is stalled
    @(posedge clk); #1 source_ready = 0;
    send_frame(8, 8, 7, 0, 100, -1, 2'b00, 1);
    send_frame(8, 8, 7, 10, 110, -1, 2'b00, 1);
    @(negedge clk);
    chk("full_ready", sink_ready, 0);
    fork
      send_frame(8, 8, 7, 20, 120, -1, 2'b00, 1);
      begin
        repeat (6) @(negedge clk);
        chk("stall_ready", sink_ready, 0);
        @(posedge clk); #1 source_ready = 1;
      end
    join
    drain();
    chk("ferr_clean", frame_err, 0);

    // early eop: dropped, sticky error; next frame fine
    send_frame(8, 6, 5, 50, 150, -1, 2'b00, 0);
    repeat (4) @(negedge clk);
    chk("ferr_set", frame_err, 1);
    chk("drop_valid", source_valid, 0);
    send_frame(8, 8, 7, 60, 160, -1, 2'b00, 1);
    drain();

    // error tag propagation
    send_frame(8, 8, 7, 70, 170, 3, 2'b01, 1);
    send_frame(8, 8, 7, 80, 180, -1, 2'b00, 1);
    drain();
    chk("ferr_sticky", frame_err, 1);

    // reset while one frame is read and another half written
    send_frame(8, 8, 7, 90, 190, -1, 2'b00, 1);
    send_frame(8, 4, -1, 30, 130, -1, 2'b00, 0);
    rst_sync = 1;
    exp_q.delete();
    @(posedge clk); #1 rst_sync = 0;
    @(negedge clk);
    chk("mid_rst_valid", source_valid, 0);
    chk("mid_rst_ready", sink_ready, 1);
    chk("mid_rst_ferr", frame_err, 0);
    @(posedge clk); #1;
    send_frame(8, 8, 7, 5, 105, -1, 2'b00, 1);
    drain();
    repeat (10) @(negedge clk);
    chk("idle_end", source_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
